// File: rtl/approx_pkg.sv
// Shared definitions for the series-approximation controller, datapath and ALU:
// ALU mode codes, controller state encoding and the default ALU latency.
package approx_pkg;

    localparam int DEFAULT_ALU_LAT = 2;
    localparam int STEP_W          = 3;

    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_SUB1 = 3'd1;
    localparam logic [2:0] MODE_ACC  = 3'd2;
    localparam logic [2:0] MODE_MUL  = 3'd3;
    localparam logic [2:0] MODE_INC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SUB1,
        ST_SEED,
        ST_ACC,
        ST_POW,
        ST_CNT,
        ST_DONE
    } approx_state_t;

endpackage

// File: rtl/approx_step_timer.sv
// Per-state step counter: runs 0..ALU_LAT, flags the terminal (write-back) step
// and restarts from 0 on clear or after the terminal step.
module approx_step_timer
    import approx_pkg::*;
#(
    parameter int ALU_LAT = DEFAULT_ALU_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    output logic [STEP_W-1:0] o_count,
    output logic              o_term
);

    logic [STEP_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear || o_term) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + STEP_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == STEP_W'(ALU_LAT));

endmodule

// File: rtl/approx_ctrl.sv
// Sequencing controller for the series-approximation datapath.
// Define APPROX_CTRL_WATCHDOG_EN to add the MAX_IT iteration watchdog driving err_o.
module approx_ctrl
    import approx_pkg::*;
#(
    parameter int ALU_LAT = DEFAULT_ALU_LAT,
    parameter int MAX_IT  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       valid_i,
    output logic       start_o,
    output logic       check_for_termination_o,
    output logic [2:0] mode_o,
    output logic       wren_x1_o,
    output logic       wren_x1_n_o,
    output logic       wren_y_o,
    output logic       wren_n_o,
    output logic       wren_sigma_n_o,
    output logic       x_to_alu_a_o,
    output logic       y_to_alu_a_o,
    output logic       x1_to_alu_a_o,
    output logic       n_to_alu_a_o,
    output logic       x1_n_to_alu_b_o,
    output logic       sigma_n_to_alu_o
);

    if (ALU_LAT < 1 || ALU_LAT > 4 || MAX_IT < 1 || MAX_IT > 7) begin : g_param_check
        $error("approx_ctrl: ALU_LAT must be 1..4 and MAX_IT 1..7");
    end

    approx_state_t     r_state;
    approx_state_t     w_next;
    logic [STEP_W-1:0] w_step;
    logic              w_term;
    logic              w_clear;
    logic              w_timeout;

    // The step counter restarts on every state change, so each state begins at step 0.
    assign w_clear = (w_next != r_state) || (r_state == ST_IDLE);

    approx_step_timer #(
        .ALU_LAT (ALU_LAT)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .o_count (w_step),
        .o_term  (w_term)
    );

`ifdef APPROX_CTRL_WATCHDOG_EN
    localparam logic [2:0] IT_LAST = 3'(MAX_IT - 1);

    logic [2:0] r_iter;
    logic       r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iter <= '0;
            r_err  <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_iter <= '0;
            r_err  <= 1'b0;
        end else if (r_state == ST_CNT && w_term) begin
            r_iter <= r_iter + 3'd1;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_timeout = !valid_i && (r_iter == IT_LAST);
    assign err_o     = (r_state == ST_DONE) && r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_i) w_next = ST_LOAD;
            ST_LOAD: if (w_step == STEP_W'(1)) w_next = ST_SUB1;
            ST_SUB1: if (w_term) w_next = ST_SEED;
            ST_SEED: if (w_term) w_next = ST_ACC;
            ST_ACC:  if (w_term) w_next = ST_POW;
            ST_POW:  if (w_term) w_next = ST_CNT;
            ST_CNT: begin
                if (w_term) begin
                    w_next = (valid_i || w_timeout) ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Moore decode of the registered state and step; write flags fire only on the last step.
    always_comb begin
        busy_o                  = (r_state != ST_IDLE);
        done_o                  = 1'b0;
        start_o                 = 1'b0;
        check_for_termination_o = 1'b0;
        mode_o                  = MODE_PASS;
        wren_x1_o               = 1'b0;
        wren_x1_n_o             = 1'b0;
        wren_y_o                = 1'b0;
        wren_n_o                = 1'b0;
        wren_sigma_n_o          = 1'b0;
        x_to_alu_a_o            = 1'b0;
        y_to_alu_a_o            = 1'b0;
        x1_to_alu_a_o           = 1'b0;
        n_to_alu_a_o            = 1'b0;
        x1_n_to_alu_b_o         = 1'b0;
        sigma_n_to_alu_o        = 1'b0;
        case (r_state)
            ST_LOAD: start_o = (w_step == '0);
            ST_SUB1: begin
                x_to_alu_a_o = 1'b1;
                mode_o       = MODE_SUB1;
                wren_x1_o    = w_term;
            end
            ST_SEED: begin
                x1_to_alu_a_o = 1'b1;
                mode_o        = MODE_PASS;
                wren_x1_n_o   = w_term;
            end
            ST_ACC: begin
                y_to_alu_a_o     = 1'b1;
                x1_n_to_alu_b_o  = 1'b1;
                sigma_n_to_alu_o = 1'b1;
                mode_o           = MODE_ACC;
                wren_y_o         = w_term;
            end
            ST_POW: begin
                x1_to_alu_a_o   = 1'b1;
                x1_n_to_alu_b_o = 1'b1;
                mode_o          = MODE_MUL;
                wren_x1_n_o     = w_term;
            end
            ST_CNT: begin
                n_to_alu_a_o            = 1'b1;
                mode_o                  = MODE_INC;
                wren_n_o                = w_term;
                wren_sigma_n_o          = w_term;
                check_for_termination_o = w_term;
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_approx_ctrl.sv
// Self-checking bench for approx_ctrl (ALU_LAT=2); expectations adapt to
// whether APPROX_CTRL_WATCHDOG_EN is defined.
module tb_approx_ctrl;
    import approx_pkg::*;

    localparam int ALU_LAT = 2;
    localparam int L       = ALU_LAT + 1;

    logic       clk;
    logic       rst;
    logic       req_i;
    logic       valid_i;
    logic       busy_o, done_o, err_o, start_o, check_for_termination_o;
    logic [2:0] mode_o;
    logic       wren_x1_o, wren_x1_n_o, wren_y_o, wren_n_o, wren_sigma_n_o;
    logic       x_to_alu_a_o, y_to_alu_a_o, x1_to_alu_a_o, n_to_alu_a_o;
    logic       x1_n_to_alu_b_o, sigma_n_to_alu_o;

    int checks;
    int errors;

    logic [4:0] expWr[$];
    logic [4:0] obsWr[$];
    int         expDone[$];
    bit         expErr[$];

    bit obsGotDone;
    int obsDoneCycle;
    bit obsErr;
    int obsStarts;
    int obsIdleGap;
    int obsViolations;

    approx_ctrl #(
        .ALU_LAT (ALU_LAT),
        .MAX_IT  (7)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_i                   (req_i),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .err_o                   (err_o),
        .valid_i                 (valid_i),
        .start_o                 (start_o),
        .check_for_termination_o (check_for_termination_o),
        .mode_o                  (mode_o),
        .wren_x1_o               (wren_x1_o),
        .wren_x1_n_o             (wren_x1_n_o),
        .wren_y_o                (wren_y_o),
        .wren_n_o                (wren_n_o),
        .wren_sigma_n_o          (wren_sigma_n_o),
        .x_to_alu_a_o            (x_to_alu_a_o),
        .y_to_alu_a_o            (y_to_alu_a_o),
        .x1_to_alu_a_o           (x1_to_alu_a_o),
        .n_to_alu_a_o            (n_to_alu_a_o),
        .x1_n_to_alu_b_o         (x1_n_to_alu_b_o),
        .sigma_n_to_alu_o        (sigma_n_to_alu_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] wrVec();
        return {wren_x1_o, wren_x1_n_o, wren_y_o, wren_n_o, wren_sigma_n_o};
    endfunction

    function automatic logic [8:0] selVec();
        return {mode_o, x_to_alu_a_o, y_to_alu_a_o, x1_to_alu_a_o, n_to_alu_a_o,
                x1_n_to_alu_b_o, sigma_n_to_alu_o};
    endfunction

    function automatic logic [18:0] allOut();
        return {busy_o, done_o, err_o, start_o, check_for_termination_o, wrVec(), selVec()};
    endfunction

    // Expected write order and completion cycle for a job of n iterations.
    task automatic pushJob(input int n, input bit err);
        expWr.push_back(5'b10000);
        expWr.push_back(5'b01000);
        for (int i = 0; i < n; i++) begin
            expWr.push_back(5'b00100);
            expWr.push_back(5'b01000);
            expWr.push_back(5'b00011);
        end
        expDone.push_back(2 + 2 * L + 3 * L * n + 1);
        expErr.push_back(err);
    endtask

    // Drives one request and records what the DUT does; valid_i is raised at CNT write validAt.
    task automatic runJob(input int budget, input bit holdReq, input int validAt);
        int         busyIdx;
        int         cntIdx;
        int         run;
        logic [8:0] prev;
        busyIdx       = 0;
        cntIdx        = 0;
        run           = 0;
        prev          = 9'h1FF;
        obsGotDone    = 1'b0;
        obsDoneCycle  = -1;
        obsErr        = 1'b0;
        obsStarts     = 0;
        obsIdleGap    = 0;
        obsViolations = 0;
        req_i         = 1'b1;
        for (int c = 0; c < budget && !obsGotDone; c++) begin
            @(negedge clk);
            if (selVec() == prev) run++;
            else begin
                run  = 1;
                prev = selVec();
            end
            if ($countones({x_to_alu_a_o, y_to_alu_a_o, x1_to_alu_a_o, n_to_alu_a_o}) > 1)
                obsViolations++;
            if (mode_o > 3'd4) obsViolations++;
            if (wrVec() != 5'b0) begin
                obsWr.push_back(wrVec());
                if (run != L) obsViolations++;
            end
            if (start_o) obsStarts++;
            if (busy_o) busyIdx++;
            else if (busyIdx == 0) obsIdleGap++;
            if (!holdReq && busy_o) req_i = 1'b0;
            if (check_for_termination_o) begin
                cntIdx++;
                valid_i = (cntIdx == validAt);
            end else begin
                valid_i = 1'($urandom_range(0, 1));
            end
            if (done_o) begin
                obsGotDone   = 1'b1;
                obsDoneCycle = busyIdx;
                obsErr       = err_o;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        req_i   = 1'b0;
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (allOut() !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0", allOut());
        end
        rst = 1'b1;
        req_i = 1'b1;
        for (int c = 0; c < 40 && mode_o != MODE_MUL; c++) begin
            @(negedge clk);
            if (busy_o) req_i = 1'b0;
        end
        checks++;
        if (!(busy_o === 1'b1 && mode_o === MODE_MUL)) begin
            errors++;
            $display("[TB] FAIL reach_pow got busy=%b mode=%0d want busy=1 mode=%0d",
                     busy_o, mode_o, MODE_MUL);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (allOut() !== 19'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_mid_pow got %h want 0", allOut());
        end
        @(negedge clk);
        rst = 1'b1;
        begin
            int active;
            active = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy_o || wrVec() != 5'b0 || start_o) active++;
            end
            checks++;
            if (active != 0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset got %0d active cycles want 0", active);
            end
        end
    endtask

    // Pops scoreboard entries and compares them with the recorded job.
    task automatic test_job(input string name, input int n, input int validAt);
        logic [4:0] e;
        logic [4:0] o;
        int         wantDone;
        bit         wantErr;
        obsWr.delete();
        pushJob(n, 1'b0);
        runJob(200, 1'b0, validAt);
        wantDone = expDone.pop_front();
        wantErr  = expErr.pop_front();
        checks++;
        if (!obsGotDone || obsDoneCycle != wantDone) begin
            errors++;
            $display("[TB] FAIL %s_done_cycle got %0d want %0d", name, obsDoneCycle, wantDone);
        end
        checks++;
        if (obsErr !== wantErr) begin
            errors++;
            $display("[TB] FAIL %s_err got %b want %b", name, obsErr, wantErr);
        end
        while (expWr.size() > 0) begin
            e = expWr.pop_front();
            o = (obsWr.size() > 0) ? obsWr.pop_front() : 5'b11111;
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL %s_write_seq got %b want %b", name, o, e);
            end
        end
        checks++;
        if (obsWr.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_extra_writes got %0d want 0", name, obsWr.size());
        end
        checks++;
        if (obsViolations != 0 || obsStarts != 1) begin
            errors++;
            $display("[TB] FAIL %s_invariants got viol=%0d starts=%0d want viol=0 starts=1",
                     name, obsViolations, obsStarts);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int wantDone;
        for (int j = 0; j < 2; j++) begin
            obsWr.delete();
            pushJob(1, 1'b0);
            runJob(60, 1'b1, 1);
            wantDone = expDone.pop_front();
            void'(expErr.pop_front());
            expWr.delete();
            checks++;
            if (!obsGotDone || obsDoneCycle != wantDone || obsStarts != 1) begin
                errors++;
                $display("[TB] FAIL b2b_job%0d got done=%0d starts=%0d want done=%0d starts=1",
                         j, obsDoneCycle, obsStarts, wantDone);
            end
            checks++;
            if (obsIdleGap != j) begin
                errors++;
                $display("[TB] FAIL b2b_gap%0d got %0d want %0d", j, obsIdleGap, j);
            end
        end
        req_i = 1'b0;
        begin
            int active;
            active = 0;
            repeat (5) begin
                @(negedge clk);
                if (start_o || (busy_o && !done_o)) active++;
            end
            checks++;
            if (active != 0) begin
                errors++;
                $display("[TB] FAIL b2b_no_third_job got %0d active cycles want 0", active);
            end
        end
        obsWr.delete();
    endtask

    task automatic test_watchdog();
`ifdef APPROX_CTRL_WATCHDOG_EN
        test_job("watchdog_dummy_guard", 0, -1);
`else
        obsWr.delete();
        runJob(300, 1'b0, 0);
        checks++;
        if (obsGotDone || !busy_o) begin
            errors++;
            $display("[TB] FAIL no_watchdog_hang got done=%b busy=%b want done=0 busy=1",
                     obsGotDone, busy_o);
        end
        checks++;
        if (obsViolations != 0) begin
            errors++;
            $display("[TB] FAIL no_watchdog_invariants got %0d want 0", obsViolations);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        obsWr.delete();
`endif
    endtask

`ifdef APPROX_CTRL_WATCHDOG_EN
    task automatic test_watchdog_on();
        int wantDone;
        obsWr.delete();
        pushJob(7, 1'b1);
        runJob(200, 1'b0, 0);
        wantDone = expDone.pop_front();
        checks++;
        if (!obsGotDone || obsDoneCycle != wantDone || obsErr !== expErr.pop_front()) begin
            errors++;
            $display("[TB] FAIL watchdog_abort got done=%0d err=%b want done=%0d err=1",
                     obsDoneCycle, obsErr, wantDone);
        end
        checks++;
        if (obsWr.size() != expWr.size() || obsViolations != 0) begin
            errors++;
            $display("[TB] FAIL watchdog_writes got %0d viol=%0d want %0d viol=0",
                     obsWr.size(), obsViolations, expWr.size());
        end
        expWr.delete();
        obsWr.delete();
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_job("single", 1, 1);
        test_job("three", 3, 3);
        test_back_to_back();
`ifdef APPROX_CTRL_WATCHDOG_EN
        test_watchdog_on();
`else
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_ctrl.md
# approx_ctrl

Sequencing controller for the series-approximation datapath. It accepts a compute request, pulses `start` into the datapath, and issues the per-step ALU mode, register-transfer selects and write flags. It runs iterations until the datapath reports termination, then signals completion. The block sits between the system request interface and the datapath/ALU pair; it holds no arithmetic state of its own.

## Interface
Parameters:
- `ALU_LAT`, 2: cycles from operand select to valid write-back bus; range 1..4.
- `MAX_IT`, 7: watchdog iteration limit, used only with the watchdog compiled in.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `req_i` in 1: compute request, sampled in IDLE only.
- `busy_o` out 1: high from request accept until the DONE cycle inclusive.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: watchdog abort, valid together with `done_o`.
- `valid_i` in 1: termination flag from the datapath.
- `start_o`, `check_for_termination_o` out 1: datapath control.
- `mode_o` out 3: ALU mode.
- `wren_x1_o`, `wren_x1_n_o`, `wren_y_o`, `wren_n_o`, `wren_sigma_n_o` out 1: write flags.
- `x_to_alu_a_o`, `y_to_alu_a_o`, `x1_to_alu_a_o`, `n_to_alu_a_o`, `x1_n_to_alu_b_o`, `sigma_n_to_alu_o` out 1: transfer selects. At most one `*_to_alu_a_o` is high at any time.

## Operation
- States: IDLE, LOAD, SUB1, SEED, ACC, POW, CNT, DONE.
- IDLE: all outputs 0. `req_i`=1 moves to LOAD.
- LOAD: 2 cycles. `start_o`=1 in the first cycle only; the second cycle covers the datapath's registered start.
- Op states hold their selects and mode for ALU_LAT+1 cycles. A step counter runs 0..ALU_LAT. The state's write flag is high only when the counter equals ALU_LAT. The transition happens on that cycle.
- SUB1: `x_to_alu_a_o`, mode SUB1; write `wren_x1_o`.
- SEED: `x1_to_alu_a_o`, mode PASS; write `wren_x1_n_o`.
- ACC: `y_to_alu_a_o`, `x1_n_to_alu_b_o`, `sigma_n_to_alu_o`, mode ACC; write `wren_y_o`.
- POW: `x1_to_alu_a_o`, `x1_n_to_alu_b_o`, mode MUL; write `wren_x1_n_o`.
- CNT: `n_to_alu_a_o`, mode INC. In the write cycle, `wren_n_o`, `wren_sigma_n_o` and `check_for_termination_o` are high together.
  - If `valid_i`=1 in that cycle, go to DONE.
  - Otherwise go to ACC.
- DONE: 1 cycle, `done_o`=1, then IDLE.
- `req_i` during busy is ignored; it is not queued.
- Reset mid-operation returns to IDLE immediately; no partial write is issued. The datapath is re-initialised by the next `start_o`.

## Timing
- All outputs are registered Moore outputs. Reset value of every output is 0.
- Request accept: `req_i` high at edge k gives `start_o`=1 and `busy_o`=1 after edge k.
- L = ALU_LAT+1 cycles per op step.
- Total latency from the first busy cycle to `done_o`, inclusive: 2 + 2L + 3L·N + 1, for N iterations. With ALU_LAT=2: 9 + 9N.
- `valid_i` is sampled only in the CNT write cycle. Any other value of `valid_i` is don't-care.
- Mode encodings are 3 bits: PASS=0, SUB1=1, ACC=2, MUL=3, INC=4. Codes 5..7 are never driven.

## Configuration
- Macro: `APPROX_CTRL_WATCHDOG_EN`.
- Defined:
  - An internal 3-bit iteration counter is cleared in LOAD and incremented on each CNT write.
  - When it reaches MAX_IT with `valid_i`=0, the block goes to DONE with `err_o`=1.
  - This covers numIt=0 and the n wrap-around at 8.
- Undefined:
  - The counter is absent and `err_o` is tied to 0.
  - Termination relies solely on `valid_i`; a non-terminating numIt hangs in the ACC/POW/CNT loop until reset.

## Structure
- Package `approx_pkg`:
  - Mode constants MODE_PASS, MODE_SUB1, MODE_ACC, MODE_MUL, MODE_INC.
  - State enum `approx_state_t`.
  - Default ALU_LAT.
- Shared with the datapath and ALU so that mode codes stay in sync.
- One sub-module, `approx_step_timer`: a step counter with load, terminal flag and ALU_LAT parameter. The FSM, output decode and watchdog stay in `approx_ctrl`.

## Test plan
- Reset asserted mid-POW -> all outputs 0 asynchronously; after release, state is IDLE and no write flag appears until the next `req_i`.
- ALU_LAT=2, `req_i` pulse, `valid_i` high at the first CNT write -> `done_o` exactly 18 cycles after the first busy cycle; write sequence is x1, x1_n, y, x1_n, n/sigma.
- `valid_i` high at the third CNT write -> 3 ACC/POW/CNT rounds; `done_o` at cycle 36; `err_o`=0.
- `req_i` held high throughout busy -> exactly one `start_o` per job; a new job starts only on the cycle after DONE.
- Watchdog on, `valid_i` never high -> `done_o` with `err_o`=1 after 7 CNT writes (cycle 72).
- Watchdog off -> the same stimulus never produces `done_o`.
- Every cycle -> at most one `*_to_alu_a_o` high; write flags only high at counter==ALU_LAT; `mode_o` never 5..7.
